// File: rtl/accum_frame_adder.sv
// -----------------------------------------------------------------------------
// accum_frame_adder
//
// Framed, back-pressured accumulator stage. Operands arrive over a valid/ready
// handshake; exactly OPS operands are summed per frame. The frame total, a
// sticky carry flag and the operand count are then presented on the output
// side and held until the downstream stage accepts them.
//
// Parameters
//   WIDTH      operand / sum width in bits (default 4)
//   OPS        operands per frame, legal range 1..15 (default 4)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   clear      synchronous frame abort (drops any partial or held result)
//   in_valid   operand present on in_data
//   in_ready   block can take an operand this cycle
//   in_data    operand
//   out_valid  frame result present
//   out_ready  downstream takes the result
//   out_sum    frame sum (accumulator register)
//   out_carry  sticky flag: a carry-out occurred somewhere in the frame
//   out_count  operands accepted in the current or last frame
//
// Build option
//   ACCUM_SAT_EN  when defined, an add that carries out saturates the
//                 accumulator to all-ones instead of wrapping.
// -----------------------------------------------------------------------------
module accum_frame_adder #(
  parameter int WIDTH = 4,
  parameter int OPS   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [3:0]       out_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACC  = 2'b01,
    S_HOLD = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  // Count value at which the next accept is the last operand of the frame.
  localparam logic [3:0] LAST_CNT = 4'(OPS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic [WIDTH:0]   sum_full;
  logic             accept;

  // in_ready looks only at state, clear and rst so no input-to-output
  // combinational path exists through the data side. The unreachable 2'b11
  // encoding is excluded so a corrupted state never swallows an operand.
  assign in_ready = !rst && !clear && ((state_q == S_IDLE) || (state_q == S_ACC));
  assign accept   = in_valid && in_ready;

  // One extra bit captures the carry-out of this add.
  assign sum_full = {1'b0, acc_q} + {1'b0, in_data};

  assign out_valid = (state_q == S_HOLD);
  assign out_sum   = acc_q;
  assign out_carry = carry_q;
  assign out_count = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;

    if (clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      carry_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            // First operand of a frame overwrites the previous result.
            acc_d   = in_data;
            cnt_d   = 4'd1;
            carry_d = 1'b0;
            state_d = (OPS == 1) ? S_HOLD : S_ACC;
          end
        end

        S_ACC: begin
          if (accept) begin
            carry_d = carry_q | sum_full[WIDTH];
`ifdef ACCUM_SAT_EN
            // Once saturated the accumulator is all-ones, so any further
            // non-zero add carries out again and it stays pinned.
            acc_d = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
            acc_d = sum_full[WIDTH-1:0];
`endif
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
              state_d = S_HOLD;
            end
          end
        end

        S_HOLD: begin
          // Result registers are left untouched on release; they remain
          // visible until the next frame's first accept.
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_accum_frame_adder.sv
// -----------------------------------------------------------------------------
// tb_accum_frame_adder
//
// Scoreboard bench for accum_frame_adder. A driver feeds directed and random
// operand streams while a frame-level reference model predicts in_ready,
// out_valid and out_count each cycle and pushes the expected frame result
// into a queue. A separate monitor compares every presented result against
// the head of that queue and pops it on the output handshake.
// -----------------------------------------------------------------------------
module tb_accum_frame_adder;

  localparam int WIDTH = 4;
  localparam int OPS   = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic [3:0]       out_count;

  accum_frame_adder #(.WIDTH(WIDTH), .OPS(OPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int carry;
    int count;
  } result_t;

  result_t sb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: operands of the frame in progress, whether a
  // result is being presented, and the operand count the block should show.
  int m_ops[$];
  bit m_hold = 1'b0;
  int m_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Frame result from plain arithmetic on the whole operand list.
  task automatic push_expect();
    result_t r;
    int total = 0;
    foreach (m_ops[i]) total += m_ops[i];
`ifdef ACCUM_SAT_EN
    r.sum = (total > MAXV) ? MAXV : total;
`else
    r.sum = total % (MAXV + 1);
`endif
    r.carry = (total > MAXV) ? 1 : 0;
    r.count = OPS;
    sb.push_back(r);
    $display("frame ops=%p -> sum=%0d carry=%0d", m_ops, r.sum, r.carry);
  endtask

  // One clock cycle: apply inputs, check handshake-side outputs against the
  // model, advance the model across the coming rising edge.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit ordy,
                       input bit clr, output bit acc);
    int exp_rdy;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
    exp_rdy = (!clr && !m_hold) ? 1 : 0;
    check("in_ready", int'(in_ready), exp_rdy);
    check("out_valid", int'(out_valid), int'(m_hold));
    check("out_count", int'(out_count), m_cnt);
    acc = 1'b0;
    if (clr) begin
      if (m_hold) void'(sb.pop_back());
      m_hold = 1'b0;
      m_ops.delete();
      m_cnt = 0;
    end else if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (v) begin
      acc = 1'b1;
      m_ops.push_back(int'(d));
      m_cnt = m_ops.size();
      if (m_ops.size() == OPS) begin
        push_expect();
        m_ops.delete();
        m_hold = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input int d, input int gap, input bit ordy);
    bit a;
    a = 1'b0;
    repeat (gap) cycle(1'b0, '0, ordy, 1'b0, a);
    a = 1'b0;
    for (int k = 0; k < 50 && !a; k++) cycle(1'b1, WIDTH'(d), ordy, 1'b0, a);
    if (!a) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) cycle(1'b0, '0, 1'b1, 1'b0, a);
  endtask

  task automatic frame(input int a0, input int a1, input int a2, input int a3);
    push_op(a0, 0, 1'b1);
    push_op(a1, 0, 1'b1);
    push_op(a2, 0, 1'b1);
    push_op(a3, 0, 1'b1);
  endtask

  // Monitor: compare whatever result is presented with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !clear && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result at %0t: got sum=%0d with no frame expected", $time, out_sum);
      end else begin
        check("out_sum", int'(out_sum), sb[0].sum);
        check("out_carry", int'(out_carry), sb[0].carry);
        check("result_count", int'(out_count), sb[0].count);
        if (out_ready) begin
          $display("result taken: sum=%0d carry=%0d count=%0d", out_sum, out_carry, out_count);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_carry", int'(out_carry), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back frame, immediate acceptance.
    frame(1, 2, 3, 4);
    idle(2);

    // Overflow: wrap or saturate depending on build.
    frame(8, 8, 1, 1);
    idle(2);

    // Back-pressure held for five cycles with in_valid asserted.
    push_op(5, 0, 1'b0); push_op(5, 0, 1'b0); push_op(5, 0, 1'b0); push_op(5, 0, 1'b0);
    repeat (5) cycle(1'b1, 4'd7, 1'b0, 1'b0, a);
    frame(1, 1, 2, 2);
    idle(2);

    // Abort mid-frame with an operand offered in the clear cycle.
    push_op(3, 0, 1'b1); push_op(3, 0, 1'b1);
    cycle(1'b1, 4'd9, 1'b1, 1'b1, a);
    frame(1, 1, 1, 1);
    idle(2);

    // Clear and out_ready together while holding: result dropped.
    frame(6, 6, 6, 6);
    cycle(1'b0, '0, 1'b1, 1'b1, a);
    idle(2);

    // Asynchronous reset between clock edges after two operands.
    push_op(2, 0, 1'b1); push_op(2, 0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_sum", int'(out_sum), 0);
    check("async_rst_count", int'(out_count), 0);
    check("async_rst_ready", int'(in_ready), 0);
    if (m_hold) void'(sb.pop_back());
    m_hold = 1'b0; m_ops.delete(); m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    frame(2, 2, 2, 2);
    idle(2);

    // Bubbles between operands.
    push_op(1, 1, 1'b1); push_op(2, 3, 1'b1); push_op(3, 2, 1'b1); push_op(4, 1, 1'b1);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 39) == 0, a);
    end
    idle(4);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_frame_adder.md
# accum_frame_adder

Sequential accumulator that sits directly upstream of the team's 4-bit `full_adder` result consumers. It takes a stream of WIDTH-bit operands over a valid/ready handshake and sums exactly OPS operands per frame. It presents the frame total with a sticky carry flag and an operand count, and holds them until the downstream stage accepts them. It turns the combinational adder into a framed, back-pressured pipeline stage.

## Interface
- `WIDTH`, 4: operand and sum width in bits.
- `OPS`, 4: operands per frame; legal range 1..15.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `clear`  input  1  synchronous frame abort; highest priority after `rst`.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_ready`  output  1  block accepts an operand this cycle.
- `in_data`  input  WIDTH  operand.
- `out_valid`  output  1  frame result is valid.
- `out_ready`  input  1  downstream accepts the result.
- `out_sum`  output  WIDTH  frame sum, driven from the accumulator register.
- `out_carry`  output  1  sticky flag: any carry-out occurred during the frame.
- `out_count`  output  4  number of operands accepted in the current or last frame.

## Operation
- Registers: `state` (2 bits), `acc` (WIDTH), `cnt` (4), `carry` (1).
- Outputs: `out_sum`=`acc`, `out_carry`=`carry`, `out_count`=`cnt`, `out_valid`=(`state`==S_HOLD).
- Accept condition: `in_valid && in_ready`.
- `in_ready` = !`rst` && !`clear` && (`state`!=S_HOLD).
- Sum rule: `{c, s}` = `acc` + `in_data`, evaluated at WIDTH+1 bits.
- **S_IDLE (2'b00):**
  - On accept: `acc`<=`in_data`; `cnt`<=1; `carry`<=0.
  - Next state is S_HOLD if OPS==1, else S_ACC.
- **S_ACC (2'b01):**
  - On accept: `acc`<=`s`; `carry`<=`carry`|`c`; `cnt`<=`cnt`+1.
  - When `cnt`==OPS-1, this accept completes the frame; go to S_HOLD.
- **S_HOLD (2'b10):**
  - `in_valid` is ignored.
  - On `out_ready`: go to S_IDLE. `acc`, `cnt` and `carry` keep their values until the next frame's first accept overwrites them.
- `out_ready` is ignored outside S_HOLD.
- `clear`: `state`<=S_IDLE and `acc`,`cnt`,`carry`<=0.
  - No operand is accepted in a `clear` cycle.
  - A result in S_HOLD is discarded.
- Encoding 2'b11 is illegal. It must go to S_IDLE with registers cleared.

## Timing
- Reset values: `state`=S_IDLE; `acc`=0, `cnt`=0, `carry`=0.
  - So `out_valid`=0, `out_sum`=0, `out_carry`=0, `out_count`=0.
  - `in_ready`=0 while `rst` is high and 1 after release.
- Latency: `out_valid` rises the cycle after the OPS-th accept.
- Throughput: one operand per cycle. There is one dead input cycle per frame (the S_HOLD cycle) when `out_ready` is tied high.
- Bubbles on `in_valid` stall accumulation without affecting the result.
- Back-pressure: while `out_valid` && !`out_ready`, `out_sum`, `out_carry` and `out_count` are stable and `in_ready`=0.
- Same-cycle `clear` with `out_ready` in S_HOLD: `clear` wins, and the result is considered dropped.
- `rst` mid-frame clears all state immediately, without waiting for a clock edge.
- No combinational path from `in_valid`, `in_data` or `out_ready` to any output. `in_ready` depends only on `state`, `clear` and `rst`.

## Configuration
- `ACCUM_SAT_EN` defined: on a carry-out, `acc`<=all-ones instead of `s`, and `carry`<=1. Later adds in the same frame keep `acc` at all-ones.
- `ACCUM_SAT_EN` undefined: sums wrap modulo 2^WIDTH; `carry` is still sticky.

## Test plan
- Defaults WIDTH=4, OPS=4.
- Reset, then operands 1,2,3,4 back-to-back with `out_ready`=1 -> `out_valid` one cycle after the 4th accept, `out_sum`=4'hA, `out_carry`=0, `out_count`=4, `in_ready` low for exactly that cycle.
- Operands 8,8,1,1 -> without `ACCUM_SAT_EN`: `out_sum`=4'h2, `out_carry`=1. With `ACCUM_SAT_EN`: `out_sum`=4'hF, `out_carry`=1.
- Frame 5,5,5,5 with `out_ready`=0 for 5 cycles while `in_valid`=1 -> `out_valid` held, `out_sum`=4'h4 and `out_carry`=1 stable, `in_ready`=0, no operand consumed; after `out_ready`=1 the next frame starts cleanly.
- Accept 3,3, then pulse `clear` with `in_valid`=1 -> that operand is not accepted, `out_count`=0; next frame 1,1,1,1 gives `out_sum`=4'h4, `out_count`=4.
- Assert `rst` asynchronously between clock edges after 2 operands -> `out_sum`=0 and `out_count`=0 immediately; after release, frame 2,2,2,2 gives `out_sum`=4'h8.
- Frame 1,2,3,4 with 1-3 idle cycles between operands -> identical result to the first scenario.
